sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 161 ++++++++++++++++
 tb/tb_sw_debounce.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - tick-sampled per-bit switch debouncer with edge pulses
// Optional feature macro: SW_DEBOUNCE_TOGGLE_EN adds a per-bit push-button toggle latch output.
module sw_debounce #(
  parameter int WIDTH    = 16,
  parameter int STABLE_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
`ifdef SW_DEBOUNCE_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] toggle
`endif
);

  // Counter wide enough to hold STABLE_N so the compare never wraps.
  localparam int CW = $clog2(STABLE_N + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] clean_dly_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             changed_q;
  logic             changed_d;

  db_state_e        state_q [WIDTH];
  db_state_e        state_d [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];

  // Two-flop synchroniser per bit, runs every clock regardless of tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce FSM next state: only a tick can move state, count or clean.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick) begin
        case (state_q[i])
          ST_STABLE: begin
            if (sync2_q[i] != clean_q[i]) begin
              state_d[i] = ST_PENDING;
              cnt_d[i]   = CNT_ONE;
            end
          end
          ST_PENDING: begin
            if (sync2_q[i] == clean_q[i]) begin
              // Input bounced back before qualifying: drop the attempt.
              state_d[i] = ST_STABLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] >= CNT_LAST) begin
              // Enough consecutive samples: accept the new level now.
              clean_d[i] = ~clean_q[i];
              state_d[i] = ST_STABLE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Per-bit FSM state, counter and debounced level registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      clean_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clean_q <= clean_d;
    end
  end

  // Edge detect from registered clean versus its one-clock delayed copy.
  always_comb begin
    rise_d    = clean_q & ~clean_dly_q;
    fall_d    = ~clean_q & clean_dly_q;
    changed_d = |(clean_q ^ clean_dly_q);
  end

  // Delayed copy and registered edge pulses, so pulses trail clean by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clean_dly_q <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      changed_q   <= 1'b0;
    end else begin
      clean_dly_q <= clean_q;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      changed_q   <= changed_d;
    end
  end

`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [WIDTH-1:0] toggle_q;
  logic [WIDTH-1:0] toggle_d;

  // Push-button latch: each rise pulse flips the bit.
  always_comb begin
    toggle_d = toggle_q ^ rise_q;
  end

  // Toggle latch register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign toggle = toggle_q;
`endif

  assign clean   = clean_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce
module tb_sw_debounce;

  localparam int WIDTH    = 16;
  localparam int STABLE_N = 4;

  logic             clk;
  logic             rst;
  logic             tick;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;
`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [WIDTH-1:0] toggle;
`endif

  int n_cmp;
  int n_mis;
  int rise_cnt;
  int fall_cnt;
  int chg_cnt;

  sw_debounce #(
    .WIDTH   (WIDTH),
    .STABLE_N(STABLE_N)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .raw_in (raw_in),
    .clean  (clean),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
`ifdef SW_DEBOUNCE_TOGGLE_EN
    ,
    .toggle (toggle)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Nine idle clocks then a one-clock tick; returns at the negedge after the tick edge.
  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (9) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  // Pulse bookkeeping and per-cycle consistency of the pulse outputs.
  always @(negedge clk) begin
    if (rst) begin
      check("rise_fall_excl", 32'(rise & fall), 32'h0);
      check("changed_is_or", 32'(changed), 32'(|(rise | fall)));
      rise_cnt += $countones(rise);
      fall_cnt += $countones(fall);
      chg_cnt  += int'(changed);
    end
  end

  initial begin
    n_cmp = 0; n_mis = 0;
    rise_cnt = 0; fall_cnt = 0; chg_cnt = 0;
    rst = 1'b0; tick = 1'b0; raw_in = '0;
    repeat (3) @(negedge clk);
    check("rst_clean", 32'(clean), 32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fall", 32'(fall), 32'h0);
    check("rst_changed", 32'(changed), 32'h0);
    rst = 1'b1;

    // Clean press on bit 0.
    raw_in[0] = 1'b1;
    tick_n(3);
    check("press_clean_3t", 32'(clean), 32'h0);
    tick_n(1);
    check("press_clean_4t", 32'(clean), 32'h1);
    check("press_rise_early", 32'(rise), 32'h0);
    @(negedge clk);
    check("press_rise", 32'(rise), 32'h1);
    check("press_changed", 32'(changed), 32'h1);
    @(negedge clk);
    check("press_rise_end", 32'(rise), 32'h0);
    check("press_changed_end", 32'(changed), 32'h0);

    // Bounce on bit 3: never qualifies.
    for (int c = 0; c < 60; c++) begin
      raw_in[3] = ((c / 15) % 2 == 0);
      tick = (c % 10 == 9);
      @(negedge clk);
    end
    tick = 1'b0;
    raw_in[3] = 1'b0;
    tick_n(6);
    check("bounce_clean", 32'(clean), 32'h1);
    check("bounce_rise_cnt", 32'(rise_cnt), 32'd1);
    check("bounce_fall_cnt", 32'(fall_cnt), 32'd0);

    // Release of bit 0 with a bounce back after three ticks.
    raw_in[0] = 1'b0;
    tick_n(3);
    check("rel_clean_3t", 32'(clean), 32'h1);
    raw_in[0] = 1'b1;
    tick_n(1);
    check("rel_bounce_clean", 32'(clean), 32'h1);
    raw_in[0] = 1'b0;
    tick_n(3);
    check("rel_clean_restart", 32'(clean), 32'h1);
    tick_n(1);
    check("rel_clean_done", 32'(clean), 32'h0);
    @(negedge clk);
    check("rel_fall", 32'(fall), 32'h1);
    check("rel_changed", 32'(changed), 32'h1);

    // All bits of a pattern at once.
    raw_in = 16'hA5A5;
    tick_n(3);
    check("multi_clean_3t", 32'(clean), 32'h0);
    tick_n(1);
    check("multi_clean", 32'(clean), 32'hA5A5);
    @(negedge clk);
    check("multi_rise", 32'(rise), 32'hA5A5);
    check("multi_fall", 32'(fall), 32'h0);
    check("multi_changed", 32'(changed), 32'h1);
    @(negedge clk);
    check("multi_rise_end", 32'(rise), 32'h0);
    raw_in = 16'h0000;
    tick_n(4);
    @(negedge clk);
    check("multi_fall_all", 32'(fall), 32'hA5A5);

    // Reset in the middle of a pending change.
    raw_in = 16'h0003;
    tick_n(4);
    check("pre_rst_clean", 32'(clean), 32'h3);
    raw_in = 16'h0013;
    tick_n(2);
    #2 rst = 1'b0;
    #1;
    check("async_rst_clean", 32'(clean), 32'h0);
    check("async_rst_rise", 32'(rise), 32'h0);
    check("async_rst_fall", 32'(fall), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tick_n(3);
    check("post_rst_clean_3t", 32'(clean), 32'h0);
    tick_n(1);
    check("post_rst_clean", 32'(clean), 32'h13);
    @(negedge clk);
    check("post_rst_rise", 32'(rise), 32'h13);

    repeat (3) @(negedge clk);
    check("total_rise", 32'(rise_cnt), 32'd14);
    check("total_fall", 32'(fall_cnt), 32'd9);
    check("total_changed", 32'(chg_cnt), 32'd6);
`ifdef SW_DEBOUNCE_TOGGLE_EN
    check("toggle_final", 32'(toggle), 32'h13);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
